// File: rtl/store_write_buffer_pkg.sv
// Shared types and default sizes for the post-commit store write buffer.
package store_write_buffer_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SWB_DEPTH  = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } MemAccessType;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } swb_entry_t;

  typedef enum logic {
    SWB_IDLE = 1'b0,
    SWB_SEND = 1'b1
  } SwbState;

endpackage

// File: rtl/store_write_buffer_match_unit.sv
// Youngest-first word-address match over the circular store array.
module swb_match_unit #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [$clog2(DEPTH)-1:0]          head,
  input  logic [$clog2(DEPTH)-1:0]          tail,
  input  logic [DEPTH-1:0]                  valid,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]  addrs,
  input  logic [ADDR_WIDTH-1:0]             ld_addr,
  output logic                              hit,
  output logic [$clog2(DEPTH)-1:0]          idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] pos;
  logic             stop;

  // Walk from tail-1 back towards head; the first match found is the youngest.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    pos  = '0;
    stop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = tail - PTR_W'(1) - PTR_W'(i);
      if (!stop && !hit && valid[pos] &&
          addrs[pos][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) begin
        hit = 1'b1;
        idx = pos;
      end
      if (pos == head) stop = 1'b1;
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Post-commit store FIFO draining to the D-cache, with load hazard checking.
// Optional store-to-load forwarding enabled by STORE_WRITE_BUFFER_LOAD_FWD_EN.
import store_write_buffer_pkg::*;

module store_write_buffer #(
  parameter int DEPTH      = SWB_DEPTH,
  parameter int ADDR_WIDTH = store_write_buffer_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = store_write_buffer_pkg::DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_wr_en,
  input  logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]      mem_wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dc_valid,
  output MemAccessType               dc_mem_action,
  output logic [ADDR_WIDTH-1:0]      dc_addr,
  output logic [DATA_WIDTH-1:0]      dc_data,
  input  logic                       dc_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  output logic                       ld_stall,
  output logic                       fwd_hit,
  output logic [DATA_WIDTH-1:0]      fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                  head;
  logic [PTR_W-1:0]                  tail;
  logic [CNT_W-1:0]                  count_n;
  logic [DEPTH-1:0]                  valid;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]  addr_mem;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  data_mem;
  SwbState                           state;
  SwbState                           state_n;
  logic                              push;
  logic                              pop;
  logic                              buf_hit;
  logic [PTR_W-1:0]                  buf_idx;
  logic                              inc_match;

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign push          = mem_wr_en && !full;
  assign dc_valid      = (state == SWB_SEND);
  assign pop           = dc_valid && dc_ready;
  assign dc_mem_action = WRITE;
  assign dc_addr       = dc_valid ? addr_mem[head] : '0;
  assign dc_data       = dc_valid ? data_mem[head] : '0;

  always_comb begin
    count_n = count + CNT_W'(push) - CNT_W'(pop);
    state_n = state;
    case (state)
      SWB_IDLE: if (count_n != '0) state_n = SWB_SEND;
      SWB_SEND: if (count_n == '0) state_n = SWB_IDLE;
      default:  state_n = SWB_IDLE;
    endcase
  end

  // Control state: pointers, occupancy, entry valid bits and drain FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      state <= SWB_IDLE;
    end else begin
      if (push) begin
        tail        <= tail + PTR_W'(1);
        valid[tail] <= 1'b1;
      end
      if (pop) begin
        head        <= head + PTR_W'(1);
        valid[head] <= 1'b0;
      end
      count <= count_n;
      state <= state_n;
      assert (!(mem_wr_en && full))
        else $warning("store commit dropped: buffer full");
    end
  end

  // Entry payload needs no reset; valid bits and dc_* gating cover it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= mem_wr_addr;
      data_mem[tail] <= mem_wr_data;
    end
  end

  swb_match_unit #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_match (
    .head    (head),
    .tail    (tail),
    .valid   (valid),
    .addrs   (addr_mem),
    .ld_addr (ld_addr),
    .hit     (buf_hit),
    .idx     (buf_idx)
  );

  assign inc_match = push && (mem_wr_addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]);

`ifdef STORE_WRITE_BUFFER_LOAD_FWD_EN
  // The same-cycle commit is younger than anything already buffered.
  assign fwd_hit  = ld_valid && (inc_match || buf_hit);
  assign fwd_data = !fwd_hit ? '0 : (inc_match ? mem_wr_data : data_mem[buf_idx]);
  assign ld_stall = 1'b0;
`else
  logic unused_idx;
  assign unused_idx = ^buf_idx;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  assign ld_stall   = ld_valid && (inc_match || buf_hit);
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer; expectations follow STORE_WRITE_BUFFER_LOAD_FWD_EN.
import store_write_buffer_pkg::*;

module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        dc_valid;
  MemAccessType dc_mem_action;
  logic [31:0] dc_addr;
  logic [31:0] dc_data;
  logic        dc_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int checks   = 0;
  int failures = 0;

  store_write_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .dc_valid      (dc_valid),
    .dc_mem_action (dc_mem_action),
    .dc_addr       (dc_addr),
    .dc_data       (dc_data),
    .dc_ready      (dc_ready),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_stall      (ld_stall),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d);
    mem_wr_en   = 1'b1;
    mem_wr_addr = a;
    mem_wr_data = d;
    tick();
    mem_wr_en   = 1'b0;
  endtask

  // Checks the load port against a match that should forward `d`.
  task automatic check_match(input string tag, input logic [31:0] d);
`ifdef STORE_WRITE_BUFFER_LOAD_FWD_EN
    check({tag, "_hit"},   fwd_hit,  1'b1);
    check({tag, "_data"},  fwd_data, d);
    check({tag, "_stall"}, ld_stall, 1'b0);
`else
    check({tag, "_stall"}, ld_stall, 1'b1);
    check({tag, "_hit"},   fwd_hit,  1'b0);
    check({tag, "_data"},  fwd_data, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    dc_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_full",     full,     1'b0);
    check("rst_empty",    empty,    1'b1);
    check("rst_count",    count,    3'd0);
    check("rst_dc_valid", dc_valid, 1'b0);
    check("rst_dc_addr",  dc_addr,  32'h0);
    check("rst_dc_data",  dc_data,  32'h0);
    check("rst_action",   dc_mem_action, WRITE);
    check("rst_stall",    ld_stall, 1'b0);
    check("rst_fwd_hit",  fwd_hit,  1'b0);
    check("rst_fwd_data", fwd_data, 32'h0);

    // Single store, latency 1 to the D-cache, drained the following edge.
    dc_ready = 1'b1;
    commit(32'h100, 32'hAAAA);
    check("one_valid", dc_valid, 1'b1);
    check("one_addr",  dc_addr,  32'h100);
    check("one_data",  dc_data,  32'hAAAA);
    check("one_count", count,    3'd1);
    tick();
    check("one_empty", empty,    1'b1);
    check("one_idle",  dc_valid, 1'b0);

    // Fill with D-cache stalled, then a dropped fifth commit.
    dc_ready = 1'b0;
    for (int i = 0; i < 4; i++) commit(32'h400 + 32'(4 * i), 32'h10 + 32'(i));
    check("fill_full",  full,  1'b1);
    check("fill_count", count, 3'd4);
    commit(32'h500, 32'h55);
    check("drop_count", count,   3'd4);
    check("drop_head",  dc_addr, 32'h400);
    tick(); tick();
    check("hold_valid", dc_valid, 1'b1);
    check("hold_addr",  dc_addr,  32'h400);
    check("hold_data",  dc_data,  32'h10);

    dc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", dc_valid, 1'b1);
      check("drain_addr",  dc_addr,  32'h400 + 32'(4 * i));
      check("drain_data",  dc_data,  32'h10 + 32'(i));
      tick();
    end
    check("drain_empty", empty,    1'b1);
    check("drain_idle",  dc_valid, 1'b0);
    check("drain_full",  full,     1'b0);

    // Two stores to the same word; load with byte offset.
    dc_ready = 1'b0;
    commit(32'h200, 32'h1);
    commit(32'h200, 32'h2);
    ld_valid = 1'b1; ld_addr = 32'h202; #1;
    check_match("ld2", 32'h2);
    ld_addr = 32'h204; #1;
    check("miss_stall", ld_stall, 1'b0);
    check("miss_hit",   fwd_hit,  1'b0);
    ld_valid = 1'b0; ld_addr = 32'h202; #1;
    check("nold_stall", ld_stall, 1'b0);
    check("nold_hit",   fwd_hit,  1'b0);
    ld_valid = 1'b1;
    dc_ready = 1'b1;
    tick();
    check_match("ld1", 32'h2);
    tick();
    check("ld0_stall", ld_stall, 1'b0);
    check("ld0_hit",   fwd_hit,  1'b0);
    check("ld0_empty", empty,    1'b1);

    // Same-cycle commit matches on an empty buffer, then beats a buffered one.
    dc_ready = 1'b0;
    ld_addr = 32'h300;
    mem_wr_en = 1'b1; mem_wr_addr = 32'h300; mem_wr_data = 32'h7; #1;
    check_match("inc", 32'h7);
    tick();
    mem_wr_data = 32'h8; #1;
    check_match("young", 32'h8);
    tick();
    mem_wr_addr = 32'h304; mem_wr_data = 32'h9; #1;
    check_match("buf", 32'h8);
    tick();
    mem_wr_en = 1'b0;
    check("pre_rst_count", count, 3'd3);

    // Reset with entries pending discards them.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_empty", empty,    1'b1);
    check("rst2_valid", dc_valid, 1'b0);
    check("rst2_count", count,    3'd0);
    check("rst2_stall", ld_stall, 1'b0);
    check("rst2_hit",   fwd_hit,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
